// File: rtl/serial_add_if.sv
// Operand/result handshake bundle for the digit-serial adder.
// master drives operands and result acceptance; slave is the adder side.
interface serial_add_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add.sv
// Digit-serial adder/subtractor: W result bits per clock through a W-bit carry chain,
// with valid/ready on both sides and carry/borrow-out plus signed overflow.
module serial_add #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  io
);

  localparam int WS = (W < 1) ? 1 : W;
  localparam int K  = N / WS;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (W < 1 || W > N) begin : g_badWidth
    $error("serial_add: W=%0d must satisfy 1 <= W <= N=%0d", W, N);
  end else if ((N % WS) != 0) begin : g_badDivide
    $error("serial_add: N=%0d must be divisible by W=%0d", N, W);
  end

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  opA_q, opA_d;
  logic [N-1:0]  opB_q, opB_d;
  logic          carry_q, carry_d;
  logic          subMode_q, subMode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          outValid_q, outValid_d;

  logic [W:0]    digitSum;
  logic          digitCarry;
  logic          topCarryIn;
  logic [N-1:0]  shiftNext;

  assign digitSum   = {1'b0, opA_q[W-1:0]} + {1'b0, opB_q[W-1:0]} + {{W{1'b0}}, carry_q};
  assign digitCarry = digitSum[W];

  // Overflow needs the carry entering the operand MSB, which sits inside the last digit.
  if (W == 1) begin : g_topCarrySingle
    assign topCarryIn = carry_q;
  end else begin : g_topCarryMulti
    logic [W-1:0] lowSum;
    assign lowSum     = {1'b0, opA_q[W-2:0]} + {1'b0, opB_q[W-2:0]} + {{(W-1){1'b0}}, carry_q};
    assign topCarryIn = lowSum[W-1];
  end

  if (W == N) begin : g_shiftFull
    assign shiftNext = digitSum[W-1:0];
  end else begin : g_shiftPart
    assign shiftNext = {digitSum[W-1:0], shift_q[N-1:W]};
  end

  assign io.in_ready  = (state_q == IDLE) && !rst;
  assign io.out_valid = outValid_q;
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;

  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    carry_d    = carry_q;
    subMode_d  = subMode_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    outValid_d = outValid_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid && io.in_ready) begin
          // Subtract runs as a + ~b + ~cin so one carry chain serves both modes.
          opA_d     = io.a;
          opB_d     = io.sub ? ~io.b : io.b;
          carry_d   = io.sub ? ~io.cin : io.cin;
          subMode_d = io.sub;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        opA_d   = opA_q >> W;
        opB_d   = opB_q >> W;
        carry_d = digitCarry;
        cnt_d   = cnt_q + CW'(1);
        shift_d = shiftNext;
        if (cnt_q == CW'(K - 1)) begin
          sum_d      = shiftNext;
          cout_d     = subMode_q ? ~digitCarry : digitCarry;
          ovf_d      = topCarryIn ^ digitCarry;
          outValid_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      carry_q    <= 1'b0;
      subMode_q  <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      carry_q    <= carry_d;
      subMode_q  <= subMode_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      outValid_q <= outValid_d;
    end
  end

endmodule
